// File: rtl/i2s_volume_scaler.sv
// i2s_volume_scaler: I2S slave rx -> Q2.6 gain with saturation/mute -> I2S tx, one frame latency.
// All codec pins are oversampled in the CLOCK domain through 2-FF synchronisers.
module i2s_volume_scaler #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8,
    parameter logic [GAIN_W-1:0] GAIN_RST = 8'h40
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    input  logic [GAIN_W-1:0] GAIN,
    input  logic              MUTE,
    output logic              AUD_DACDAT,
    output logic              SAMPLE_VALID,
    output logic              CLIP
);
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int FRAC = GAIN_W - 2;
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    logic [1:0] bclk_sy, lrck_sy, dat_sy, warm;
    logic bclk_d, lrck_d;
    logic bclk_s, lrck_s, dat_s, ready, rise, fall, lr_chg, lr_fall;

    assign bclk_s = bclk_sy[1];
    assign lrck_s = lrck_sy[1];
    assign dat_s = dat_sy[1];
    // strobes stay quiet until the synchronisers hold real pin levels, so no false edge after reset
    assign ready = warm == 2'd3;
    assign rise = ready & bclk_s & ~bclk_d;
    assign fall = ready & ~bclk_s & bclk_d;
    assign lr_chg = ready & (lrck_s ^ lrck_d);
    assign lr_fall = lr_chg & ~lrck_s;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            bclk_sy <= '0;
            lrck_sy <= '0;
            dat_sy <= '0;
            bclk_d <= 1'b0;
            lrck_d <= 1'b0;
            warm <= '0;
        end else begin
            bclk_sy <= {bclk_sy[0], AUD_BCLK};
            lrck_sy <= {lrck_sy[0], AUD_ADCLRCK};
            dat_sy <= {dat_sy[0], AUD_ADCDAT};
            bclk_d <= bclk_s;
            lrck_d <= lrck_s;
            warm <= warm + {1'b0, warm != 2'd3};
        end
    end

    logic [CW-1:0] rx_cnt;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] sample;
    logic locked, in_data, done;

    assign in_data = locked && rise && !lr_chg && rx_cnt != '0 && rx_cnt <= LAST;
    assign done = in_data && rx_cnt == LAST;
    assign sample = {rx_sr, dat_s};

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rx_cnt <= '0;
            rx_sr <= '0;
            locked <= 1'b0;
        end else begin
            if (lr_chg) begin
                rx_cnt <= '0;
                locked <= 1'b1;
            end else if (rise && rx_cnt != '1) begin
                rx_cnt <= rx_cnt + CW'(1);
            end
            if (in_data) rx_sr <= sample[DATA_W-2:0];
        end
    end

    logic [GAIN_W-1:0] gain_act;
    logic mute_act;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            gain_act <= GAIN_RST;
            mute_act <= 1'b0;
        end else if (lr_fall) begin
            gain_act <= GAIN;
            mute_act <= MUTE;
        end
    end

    logic signed [PW-1:0] prod, q;
    logic [PW-DATA_W:0] hi;
    logic [DATA_W-1:0] sat, res, tx_left, tx_right;
    logic v1, ch1, m1, ovf;

    assign q = prod >>> FRAC;
    assign hi = q[PW-1:DATA_W-1];
    // the result fits only if every bit above the sign position agrees with it
    assign ovf = !((&hi) || !(|hi));
    assign sat = q[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    assign res = m1 ? '0 : ovf ? sat : q[DATA_W-1:0];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            prod <= '0;
            v1 <= 1'b0;
            ch1 <= 1'b0;
            m1 <= 1'b0;
            SAMPLE_VALID <= 1'b0;
            CLIP <= 1'b0;
            tx_left <= '0;
            tx_right <= '0;
        end else begin
            v1 <= done;
            if (done) begin
                prod <= PW'($signed(sample)) * PW'($signed({1'b0, gain_act}));
                ch1 <= lrck_s;
                m1 <= mute_act;
            end
            SAMPLE_VALID <= v1;
            CLIP <= v1 && !m1 && ovf;
            if (v1 && ch1) tx_right <= res;
            if (v1 && !ch1) tx_left <= res;
        end
    end

    logic [DATA_W-1:0] tx_sr;

    // zero-filling shift-out drives 0 once all DATA_W bits of the channel are gone
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            tx_sr <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (lr_chg) begin
            tx_sr <= lrck_s ? tx_right : tx_left;
            AUD_DACDAT <= 1'b0;
        end else if (fall) begin
            AUD_DACDAT <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_i2s_volume_scaler.sv
// tb_i2s_volume_scaler: directed I2S frames with hand-computed gain/saturation/mute results.
module tb_i2s_volume_scaler;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n, bclk, lrck, adc, mute, dac, sv, clip;
    logic [7:0] gain;
    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int ccnt = 0;
    int v0, c0;
    logic [15:0] gl, gr;

    i2s_volume_scaler dut (
        .CLOCK(clk),
        .RESET(rst_n),
        .AUD_BCLK(bclk),
        .AUD_ADCLRCK(lrck),
        .AUD_ADCDAT(adc),
        .GAIN(gain),
        .MUTE(mute),
        .AUD_DACDAT(dac),
        .SAMPLE_VALID(sv),
        .CLIP(clip)
    );

    always @(negedge clk) begin
        if (sv) vcnt++;
        if (clip) ccnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one channel of nb BCLKs; rise j (1..16) carries bit 16-j both ways
    task automatic chan(input logic lr, input logic [15:0] d, input int nb, input int rst_at,
                        output logic [15:0] got);
        got = '0;
        for (int j = 0; j < nb; j++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (j == 0) lrck = lr;
            adc = (j >= 1 && j <= 16) ? d[16-j] : 1'b0;
            repeat (7) @(negedge clk);
            @(negedge clk);
            bclk = 1'b1;
            if (j >= 1 && j <= 16) got[16-j] = dac;
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_dac", 32'(dac), 32'd0);
                check("rst_mid_valid", 32'(sv), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic fchk(input string tag, input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] el, input logic [15:0] er, input int ev, input int ec);
        logic [15:0] a, b;
        int vs, cs;
        vs = vcnt;
        cs = ccnt;
        chan(1'b0, l, 32, -1, a);
        chan(1'b1, r, 32, -1, b);
        check({tag, "_left"}, 32'(a), 32'(el));
        check({tag, "_right"}, 32'(b), 32'(er));
        check({tag, "_valid"}, vcnt - vs, ev);
        check({tag, "_clip"}, ccnt - cs, ec);
    endtask

    initial begin
        rst_n = 1'b0;
        bclk = 1'b1;
        lrck = 1'b1;
        adc = 1'b0;
        gain = 8'h40;
        mute = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dac", 32'(dac), 32'd0);
        check("reset_valid", 32'(sv), 32'd0);
        check("reset_clip", 32'(clip), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fchk("lock", 16'h1234, 16'hEDCC, 16'h0000, 16'h0000, 2, 0);
        gain = 8'h20;
        fchk("unity", 16'h7FFE, 16'h8001, 16'h1234, 16'hEDCC, 2, 0);
        gain = 8'hFF;
        fchk("half", 16'h4000, 16'hC000, 16'h3FFF, 16'hC000, 2, 2);

        gain = 8'h40;
        v0 = vcnt;
        c0 = ccnt;
        chan(1'b0, 16'h1111, 32, -1, gl);
        gain = 8'h00;
        chan(1'b1, 16'h2222, 32, -1, gr);
        check("sat_left", 32'(gl), 32'h7FFF);
        check("sat_right", 32'(gr), 32'h8000);
        check("sat_valid", vcnt - v0, 2);
        check("sat_clip", ccnt - c0, 0);

        fchk("gchg", 16'h5555, 16'h6666, 16'h1111, 16'h2222, 2, 0);
        mute = 1'b1;
        gain = 8'hFF;
        fchk("mute_in", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 2, 0);
        mute = 1'b0;
        gain = 8'h40;
        fchk("mute_out", 16'h0ABC, 16'h0DEF, 16'h0000, 16'h0000, 2, 0);
        fchk("resume", 16'h3333, 16'h4444, 16'h0ABC, 16'h0DEF, 2, 0);

        chan(1'b0, 16'h1111, 32, 8, gl);
        chan(1'b1, 16'h9999, 32, -1, gr);
        check("rst_right", 32'(gr), 32'h0000);
        fchk("relock", 16'h5A5A, 16'h1357, 16'h0000, 16'h9999, 2, 0);

        v0 = vcnt;
        chan(1'b0, 16'hFFFF, 10, -1, gl);
        chan(1'b1, 16'h2468, 32, -1, gr);
        check("short_left", 32'(gl), 32'h5A00);
        check("short_right", 32'(gr), 32'h1357);
        check("short_valid", vcnt - v0, 1);
        fchk("keep", 16'h0F0F, 16'hF0F0, 16'h5A5A, 16'h2468, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
